// File: rtl/fpu_pkg.sv
// Shared FPU field widths, constants and operand unpacking.
// Used by the add/sub pipelines; purely declarative, no timing.
// Denormal inputs are flushed to signed zero by fp_unpack.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int WORK_W = 27;

  localparam logic [31:0]      QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Unpacked operand: sign, biased exponent, significand with hidden bit.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
  } fp_unpacked_t;

  // Unpack an IEEE single, optionally negating it; exp==0 becomes a zero.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] v, input logic neg);
    fp_unpacked_t u;
    u.sign = v[31] ^ neg;
    u.exp  = v[30:23];
    u.sig  = (v[30:23] == '0) ? '0 : {1'b1, v[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fpu_lzc27.sv
// Leading-zero count of a 27-bit working significand.
// Purely combinational; an all-zero input reports 27.
// No handshake; used inside the normalisation stage.
module fpu_lzc27
  import fpu_pkg::*;
(
  input  logic [WORK_W-1:0] din,
  output logic [4:0]        count
);

  // Scan from LSB upward so the highest set bit wins the final assignment.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < WORK_W; i++) begin
      if (din[i]) count = 5'(WORK_W - 1 - i);
    end
  end

endmodule

// File: rtl/fsub_pipe.sv
// Pipelined single-precision subtractor y = x1 - x2, truncating, FTZ.
// Latency 3 cycles, one operation per cycle when out_ready stays high.
// Whole pipe stalls together while out_valid & ~out_ready; in_ready = en.
module fsub_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag
);

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // ---------------- stage 1: unpack, specials, swap, align ----------------
  fp_unpacked_t      u1, u2, op_a, op_b;
  logic              swap;
  logic [EXP_W-1:0]  ediff;
  logic [WORK_W-1:0] b_ext, b_raw, b_mask, b_sh;

  // Order operands by magnitude and align B to A's exponent with a sticky bit.
  always_comb begin
    u1     = fp_unpack(x1, 1'b0);
    u2     = fp_unpack(x2, 1'b1);
    swap   = {u2.exp, u2.sig} > {u1.exp, u1.sig};
    op_a   = swap ? u2 : u1;
    op_b   = swap ? u1 : u2;
    ediff  = op_a.exp - op_b.exp;
    b_ext  = {op_b.sig, 3'b000};
    b_raw  = b_ext >> ediff;
    b_mask = (27'd1 << ediff) - 27'd1;
    if (ediff >= 8'd26) b_sh = {26'd0, |op_b.sig};
    else                b_sh = {b_raw[WORK_W-1:1], b_raw[0] | (|(b_ext & b_mask))};
  end

  logic        nan1, nan2, inf1, inf2, spec, both_zero, zero_sign;
  logic [31:0] spec_val;

  // NaN/infinity handling and the signed-zero rule for zero minus zero.
  always_comb begin
    nan1      = (x1[30:23] == EXP_MAX) && (x1[22:0] != '0);
    nan2      = (x2[30:23] == EXP_MAX) && (x2[22:0] != '0);
    inf1      = (x1[30:23] == EXP_MAX) && (x1[22:0] == '0);
    inf2      = (x2[30:23] == EXP_MAX) && (x2[22:0] == '0);
    spec      = nan1 | nan2 | inf1 | inf2;
    both_zero = (x1[30:23] == '0) && (x2[30:23] == '0);
    zero_sign = x1[31] & ~x2[31];
    if (nan1 || nan2 || (inf1 && inf2 && (x1[31] == x2[31]))) spec_val = QNAN;
    else if (inf1)                                            spec_val = x1;
    else                                                      spec_val = {~x2[31], x2[30:0]};
  end

  logic              s1_vld, s1_sub, s1_sign, s1_spec, s1_zero, s1_zsign;
  logic [TAG_W-1:0]  s1_tag;
  logic [WORK_W-1:0] s1_a, s1_b;
  logic [EXP_W-1:0]  s1_exp;
  logic [31:0]       s1_spec_val;

  // Stage 1 register: captures aligned operands when the pipe advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld      <= 1'b0;
      s1_tag      <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_exp      <= '0;
      s1_sub      <= 1'b0;
      s1_sign     <= 1'b0;
      s1_spec     <= 1'b0;
      s1_spec_val <= '0;
      s1_zero     <= 1'b0;
      s1_zsign    <= 1'b0;
    end else if (en) begin
      s1_vld      <= in_valid;
      s1_tag      <= in_tag;
      s1_a        <= {op_a.sig, 3'b000};
      s1_b        <= b_sh;
      s1_exp      <= op_a.exp;
      s1_sub      <= op_a.sign ^ op_b.sign;
      s1_sign     <= op_a.sign;
      s1_spec     <= spec;
      s1_spec_val <= spec_val;
      s1_zero     <= both_zero;
      s1_zsign    <= zero_sign;
    end
  end

  // ---------------- stage 2: significand add/subtract ----------------
  logic [WORK_W:0] sum_d;

  // A has the larger magnitude, so A - B never goes negative.
  always_comb begin
    if (s1_sub) sum_d = {1'b0, s1_a} - {1'b0, s1_b};
    else        sum_d = {1'b0, s1_a} + {1'b0, s1_b};
  end

  logic              s2_vld, s2_sign, s2_spec, s2_zero, s2_zsign;
  logic [TAG_W-1:0]  s2_tag;
  logic [WORK_W:0]   s2_sum;
  logic [EXP_W-1:0]  s2_exp;
  logic [31:0]       s2_spec_val;

  // Stage 2 register: raw sum plus the fields stage 3 needs to pack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld      <= 1'b0;
      s2_tag      <= '0;
      s2_sum      <= '0;
      s2_exp      <= '0;
      s2_sign     <= 1'b0;
      s2_spec     <= 1'b0;
      s2_spec_val <= '0;
      s2_zero     <= 1'b0;
      s2_zsign    <= 1'b0;
    end else if (en) begin
      s2_vld      <= s1_vld;
      s2_tag      <= s1_tag;
      s2_sum      <= sum_d;
      s2_exp      <= s1_exp;
      s2_sign     <= s1_sign;
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
      s2_zero     <= s1_zero;
      s2_zsign    <= s1_zsign;
    end
  end

  // ---------------- stage 3: normalise, truncate, pack ----------------
  logic [4:0]        lzc;
  logic [WORK_W-1:0] norm;
  logic signed [9:0] exp_n;
  logic [31:0]       y_d;
  logic              unused_norm_bits;

  fpu_lzc27 u_lzc (
    .din   (s2_sum[WORK_W-1:0]),
    .count (lzc)
  );

  assign unused_norm_bits = ^{norm[WORK_W-1], norm[2:0]};

  // Normalise the sum, clamp the exponent and let specials override.
  always_comb begin
    if (s2_sum[WORK_W]) begin
      norm  = {s2_sum[WORK_W:2], s2_sum[1] | s2_sum[0]};
      exp_n = $signed({2'b00, s2_exp}) + 10'sd1;
    end else begin
      norm  = s2_sum[WORK_W-1:0] << lzc;
      exp_n = $signed({2'b00, s2_exp}) - $signed({5'b00000, lzc});
    end
    if (s2_spec)              y_d = s2_spec_val;
    else if (s2_zero)         y_d = {s2_zsign, 31'd0};
    else if (s2_sum == '0)    y_d = 32'd0;
    else if (exp_n >= 10'sd255) y_d = {s2_sign, EXP_MAX, 23'd0};
    else if (exp_n <= 10'sd0) y_d = {s2_sign, 31'd0};
    else                      y_d = {s2_sign, exp_n[7:0], norm[25:3]};
  end

  // Output register: result holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= s2_vld;
      y         <= y_d;
      out_tag   <= s2_tag;
    end
  end

endmodule

// File: tb/tb_fsub_pipe.sv
module tb_fsub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic [3:0]  out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_y_q[$];
  logic [3:0]  exp_tag_q[$];

  always #5 clk = ~clk;

  fsub_pipe #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_tag   (out_tag)
  );

  // Reference: exact integer difference of the two values, then truncate.
  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic signed [299:0] v1, v2, d;
    logic [299:0] mag, sh;
    logic sgn;
    int p, e;
    bit nan1, nan2, inf1, inf2, z1, z2;
    nan1 = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan2 = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inf1 = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    inf2 = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    z1 = (a[30:23] == 0);
    z2 = (b[30:23] == 0);
    if (nan1 || nan2) return 32'h7FC00000;
    if (inf1 && inf2) return (a[31] == b[31]) ? 32'h7FC00000 : a;
    if (inf1) return a;
    if (inf2) return {~b[31], b[30:0]};
    if (z1 && z2) return {a[31] & ~b[31], 31'd0};
    v1 = z1 ? '0 : ({276'd0, 1'b1, a[22:0]} << a[30:23]);
    v2 = z2 ? '0 : ({276'd0, 1'b1, b[22:0]} << b[30:23]);
    if (a[31]) v1 = -v1;
    if (b[31]) v2 = -v2;
    d = v1 - v2;
    if (d == 0) return 32'd0;
    sgn = (d < 0);
    mag = sgn ? -d : d;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 23;
    if (e >= 255) return {sgn, 8'hFF, 23'd0};
    if (e <= 0) return {sgn, 31'd0};
    sh = mag >> (p - 23);
    return {sgn, 8'(e), sh[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op(input int base);
    int k, e;
    logic s;
    k = $urandom_range(0, 24);
    s = 1'($urandom);
    case (k)
      0: return {s, 31'd0};
      1: return {s, 8'hFF, 23'd0};
      2: return {s, 8'hFF, 23'($urandom_range(1, 8388607))};
      3: return {s, 8'd0, 23'($urandom)};
      4: return $urandom;
      default: begin
        e = base + $urandom_range(0, 60) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {s, 8'(e), 23'($urandom)};
      end
    endcase
  endfunction

  task automatic test_reset();
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++;
    if (y !== 32'd0) begin n_bad++; $display("FAIL reset_y got %h want 00000000", y); end
    n_cmp++;
    if (out_tag !== 4'd0) begin n_bad++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] va[11] = '{32'h40400000, 32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                            32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h80000000,
                            32'h7FC01234};
    logic [31:0] vb[11] = '{32'h3F800000, 32'h3FA00000, 32'h3F800000, 32'hBF800000, 32'h30800000,
                            32'h00400000, 32'hFF7FFFFF, 32'h7F800000, 32'hFF800000, 32'h00000000,
                            32'h3F800000};
    logic [31:0] vy[11] = '{32'h40000000, 32'h3E800000, 32'h00000000, 32'h40000000, 32'h3F7FFFFF,
                            32'h3F800000, 32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h80000000,
                            32'h7FC00000};
    int lat;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      x1 = va[i];
      x2 = vb[i];
      in_tag = 4'(i + 3);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      #1;
      while (!out_valid && lat < 12) begin
        @(negedge clk);
        #1;
        lat++;
      end
      n_cmp++;
      if (lat !== 3) begin n_bad++; $display("FAIL dir_latency[%0d] got %0d want 3", i, lat); end
      n_cmp++;
      if (y !== vy[i]) begin n_bad++; $display("FAIL dir_y[%0d] %h-%h got %h want %h", i, va[i], vb[i], y, vy[i]); end
      n_cmp++;
      if (out_tag !== 4'(i + 3)) begin n_bad++; $display("FAIL dir_tag[%0d] got %0d want %0d", i, out_tag, i + 3); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    int issued = 0, got = 0, cyc = 0, base;
    logic held = 1'b0;
    logic [31:0] held_y;
    logic [3:0] held_tag;
    exp_y_q.delete();
    exp_tag_q.delete();
    while ((issued < 6 || got < 6) && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 9);
      in_valid  = (issued < 6);
      base = $urandom_range(20, 230);
      x1 = {1'($urandom), 8'(base), 23'($urandom)};
      x2 = {1'($urandom), 8'(base + $urandom_range(0, 6) - 3), 23'($urandom)};
      in_tag = 4'(issued);
      #1;
      n_cmp++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_bad++; $display("FAIL bp_in_ready cyc %0d got %b want %b", cyc, in_ready, !out_valid || out_ready);
      end
      if (held) begin
        n_cmp++;
        if (out_valid !== 1'b1 || y !== held_y || out_tag !== held_tag) begin
          n_bad++; $display("FAIL bp_stable cyc %0d got %b/%h/%0d want 1/%h/%0d", cyc, out_valid, y, out_tag, held_y, held_tag);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_y_q.size() == 0) begin
          n_bad++; $display("FAIL bp_extra cyc %0d got %h tag %0d want none", cyc, y, out_tag);
        end else begin
          if (y !== exp_y_q[0] || out_tag !== exp_tag_q[0]) begin
            n_bad++; $display("FAIL bp_result cyc %0d got %h/%0d want %h/%0d", cyc, y, out_tag, exp_y_q[0], exp_tag_q[0]);
          end
          void'(exp_y_q.pop_front());
          void'(exp_tag_q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_y_q.push_back(ref_sub(x1, x2));
        exp_tag_q.push_back(in_tag);
        issued++;
      end
      held = out_valid && !out_ready;
      held_y = y;
      held_tag = out_tag;
      cyc++;
    end
    n_cmp++;
    if (got !== 6 || issued !== 6) begin n_bad++; $display("FAIL bp_count got %0d results %0d issued want 6/6", got, issued); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_dup got out_valid %b tag %0d want 0", out_valid, out_tag); end
    end
  endtask

  task automatic test_random();
    int issued = 0, got = 0, cyc = 0, base;
    exp_y_q.delete();
    exp_tag_q.delete();
    while ((issued < 400 || got < issued) && cyc < 4000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (issued < 400) && ($urandom_range(0, 4) != 0);
      base = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 3 : 252) : $urandom_range(1, 254);
      x1 = rnd_op(base);
      case ($urandom_range(0, 9))
        0: x2 = x1;
        1: x2 = {~x1[31], x1[30:0]};
        default: x2 = rnd_op(base);
      endcase
      in_tag = 4'($urandom);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_y_q.size() == 0) begin
          n_bad++; $display("FAIL rnd_extra cyc %0d got %h want none", cyc, y);
        end else begin
          if (y !== exp_y_q[0] || out_tag !== exp_tag_q[0]) begin
            n_bad++; $display("FAIL rnd_result cyc %0d got %h/%0d want %h/%0d", cyc, y, out_tag, exp_y_q[0], exp_tag_q[0]);
          end
          void'(exp_y_q.pop_front());
          void'(exp_tag_q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_y_q.push_back(ref_sub(x1, x2));
        exp_tag_q.push_back(in_tag);
        issued++;
      end
      cyc++;
    end
    n_cmp++;
    if (got !== issued || issued !== 400) begin n_bad++; $display("FAIL rnd_count got %0d results %0d issued want 400/400", got, issued); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x1 = 32'h40400000;
      x2 = 32'h3F800000;
      in_tag = 4'(9 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_out_valid got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
    n_cmp++;
    if (y !== 32'd0 || out_tag !== 4'd0) begin n_bad++; $display("FAIL rst_mid_y got %h/%0d want 00000000/0", y, out_tag); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ghost cyc %0d got tag %0d want no output", i, out_tag); end
    end
    @(negedge clk);
    in_valid = 1'b1;
    x1 = 32'h3FC00000;
    x2 = 32'h3FA00000;
    in_tag = 4'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat !== 3) begin n_bad++; $display("FAIL rst_after_latency got %0d want 3", lat); end
    n_cmp++;
    if (y !== 32'h3E800000 || out_tag !== 4'd7) begin n_bad++; $display("FAIL rst_after_result got %h/%0d want 3E800000/7", y, out_tag); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsub_pipe.md
Name: fsub_pipe

Overview:
- Pipelined IEEE-754 single-precision subtractor, y = x1 - x2, for the FPU datapath next to the existing 2-cycle adder.
- Three registered stages with a valid/ready handshake, so the core can apply back-pressure.
- A tag travels alongside each operation so results can be matched to their issuing instruction.

Parameters:
TAG_W, 4, width of the opaque tag carried with each operation

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands and tag valid this cycle
in_ready  output  1  stage 1 accepts this cycle
x1  input  32  minuend, IEEE single
x2  input  32  subtrahend, IEEE single
in_tag  input  TAG_W  tag for this operation
out_valid  output  1  y and out_tag valid
out_ready  input  1  consumer accepts y this cycle
y  output  32  x1 - x2
out_tag  output  TAG_W  tag of the operation in y

Behaviour:
- Reset: one clock and one reset. Reset is asynchronous and active-high. Reset clears all stage valid bits, out_valid=0, y=0, out_tag=0. Reset asserted mid-operation discards all in-flight operations and produces no output for them.
- Advance: en = ~out_valid | out_ready. in_ready = en, and is a combinational function of out_valid and out_ready only.
- On en, all three stages shift together. Bubbles are not compressed. Stage k valid = previous stage valid, and stage 1 valid = in_valid & en.
- Latency is exactly 3 cycles with out_ready held high. Throughput is 1 per cycle.
- When en=0, every stage register holds its value, and y/out_tag remain stable while out_valid=1.
- Stage 1:
  - Negate s2.
  - Treat any exp=0 input as zero of its sign; denormals are flushed.
  - Detect specials.
  - Swap so operand A has the larger magnitude, comparing {exp,mant}.
  - Right-shift B's 24-bit significand by ediff into a 27-bit field: hidden+23, guard, round, sticky. Shift amounts of 26 or more leave only the sticky bit.
- Stage 2: 27-bit add if signs are equal, else subtract A-B. Register the sum, the larger exponent, the result sign (sign of A), and the special flags.
- Stage 3:
  - Carry-out: shift right 1, exp+1, and keep sticky.
  - Otherwise, a leading-zero count normalizes left and exp -= lzc.
  - Round toward zero: drop the guard/round/sticky bits.
  - Pack the result.
- Exponent and sign rules:
  - Exponent arithmetic is done at 10 bits signed.
  - If exp >= 255, y = {sign, 8'hFF, 23'b0}.
  - If exp <= 0, y = {sign, 31'b0}.
  - An exact-cancellation result is +0.
  - When both operands are zero, sign = s1 & ~s2.
- Specials:
  - Any NaN input gives 7FC00000.
  - Inf - inf of the same sign gives 7FC00000.
  - inf - finite gives x1.
  - finite - inf gives x2 with its sign flipped.
  - Special results override the datapath result in stage 3.
- Simultaneous events: when out_valid & out_ready & in_valid, one result leaves and one operation enters in the same cycle.

Decomposition:
- Package fpu_pkg: field widths (EXP_W=8, MAN_W=23, WORK_W=27), constants QNAN=32'h7FC00000, EXP_MAX=8'hFF, and an unpacked-operand typedef {sign, exp, sig}.
- Share fpu_pkg with fadd-era units.
- One sub-module, fpu_lzc27: combinational 27-bit leading-zero count, 5-bit output, used in stage 3.

Test Plan:
- 40400000 - 3F800000, tag 3, out_ready=1 -> y=40000000, out_tag=3, exactly 3 cycles after acceptance.
- 3FC00000 - 3FA00000 -> 3E800000. 3F800000 - 3F800000 -> 00000000. 3F800000 - BF800000 -> 40000000.
- 3F800000 - 30800000 (1.0 - 2^-30) -> 3F7FFFFF, checking the truncation toward zero and sticky bit. 3F800000 - 00400000 (denormal) -> 3F800000.
- 7F7FFFFF - FF7FFFFF -> 7F800000. 7F800000 - 7F800000 -> 7FC00000. 3F800000 - FF800000 -> 7F800000. 80000000 - 00000000 -> 80000000.
- Back-pressure: stream 6 ops with tags 0..5 and hold out_ready=0 from cycle 4 to cycle 9 -> in_ready=0 while output is held; y/out_tag stay stable; all 6 results appear in order with no loss or duplication.
- Assert rst for 1 cycle with 2 ops in flight -> out_valid=0 and y=0 immediately; the in-flight ops never appear; a new op issued after reset returns correctly in 3 cycles.
